spi_mem_master: RTL and testbench

SPI-mode-0 initiator that issues single-byte read and write transactions to the SPI memory slave (address byte, then data byte) across its serial pins. It sits on the host side of the link. It accepts a one-cycle start request with R/W, address and write data, then serialises the frame and inserts an inter-byte gap so the slave controller can complete its memory access. For reads it returns the byte captured on `miso`.

---
 rtl/spi_mem_pkg.sv | 20 ++
 rtl/spi_bit_engine.sv | 62 ++++++
 rtl/spi_mem_master.sv | 123 ++++++++++++
 tb/tb_spi_mem_master.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared constants for the SPI memory initiator: FSM encoding and frame layout.
package spi_mem_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;
    localparam logic [2:0] S_CSH   = 3'd6;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Byte 0 of a frame is {rw, addr}; rw sits in the MSB.
    function automatic int rw_bit_pos(input int data_w);
        return data_w - 1;
    endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: SCLK divider, bit counter and tx/rx shift registers.
module spi_bit_engine #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] load_data,
    input  logic              miso,
    output logic              byte_done,
    output logic              sclk,
    output logic              mosi,
    output logic [DATA_W-1:0] rx_data
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0]     div_cnt;
    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic              half_end;

    assign half_end  = (div_cnt == DW'(CLK_DIV - 1));
    // Last falling edge of the byte; a load on this same edge wins over the shift.
    assign byte_done = shift_en && sclk && half_end && (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_data <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
        end else if (load) begin
            tx_sh   <= load_data;
            mosi    <= load_data[DATA_W-1];
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
        end else if (!shift_en) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
        end else if (!half_end) begin
            div_cnt <= div_cnt + 1'b1;
        end else begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (!sclk) begin
                rx_data <= {rx_data[DATA_W-2:0], miso};
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
                tx_sh   <= {tx_sh[DATA_W-2:0], 1'b0};
                mosi    <= tx_sh[DATA_W-2];
            end
        end
    end

endmodule

// File: rtl/spi_mem_master.sv
// SPI memory initiator: one {rw,addr} byte, an idle gap, then one data byte.
module spi_mem_master
    import spi_mem_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              rw,
    input  logic [DATA_W-2:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int PH_MAX = (GAP_CYCLES > CLK_DIV) ? GAP_CYCLES : CLK_DIV;
    localparam int PW     = $clog2(PH_MAX + 1);
    localparam int RW_POS = rw_bit_pos(DATA_W);

    logic [2:0]        state;
    logic [PW-1:0]     ph_cnt;
    logic              pend;
    logic              rw_q;
    logic [DATA_W-2:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              load, shift_en, byte_done;
    logic [DATA_W-1:0] load_data, rx_data;
    logic              accept, div_last, gap_last;

    // Acceptance registers the request; SETUP (cs_n low) starts on the following edge.
    assign accept   = start && (state == S_IDLE) && !pend;
    assign div_last = (ph_cnt == PW'(CLK_DIV - 1));
    assign gap_last = (ph_cnt == PW'(GAP_CYCLES - 1));
    assign shift_en = (state == S_ADDR) || (state == S_DATA);
    assign busy     = (state != S_IDLE);
    assign cs_n     = (state == S_IDLE) || (state == S_CSH);

    always_comb begin
        load                      = 1'b0;
        load_data                 = '0;
        load_data[RW_POS]         = rw_q;
        load_data[RW_POS-1:0]     = addr_q;
        if (state == S_IDLE && pend) begin
            load = 1'b1;
        end else if (state == S_ADDR && byte_done) begin
            load      = 1'b1;
            load_data = (rw_q == RW_WRITE) ? wdata_q : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            ph_cnt  <= '0;
            pend    <= 1'b0;
            rw_q    <= RW_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            done    <= 1'b0;
            rdata   <= '0;
        end else begin
            done   <= 1'b0;
            ph_cnt <= ph_cnt + 1'b1;
            if (accept) begin
                pend    <= 1'b1;
                rw_q    <= rw;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            case (state)
                S_IDLE: begin
                    ph_cnt <= '0;
                    if (pend) begin
                        pend  <= 1'b0;
                        state <= S_SETUP;
                    end
                end
                S_SETUP: if (div_last) begin state <= S_ADDR; ph_cnt <= '0; end
                S_ADDR: begin
                    ph_cnt <= '0;
                    if (byte_done) state <= S_GAP;
                end
                S_GAP:  if (gap_last) begin state <= S_DATA; ph_cnt <= '0; end
                S_DATA: begin
                    ph_cnt <= '0;
                    if (byte_done) state <= S_HOLD;
                end
                S_HOLD: if (div_last) begin state <= S_CSH; ph_cnt <= '0; end
                S_CSH: begin
                    if (div_last) begin
                        state  <= S_IDLE;
                        ph_cnt <= '0;
                        done   <= 1'b1;
                        if (rw_q == RW_READ) rdata <= rx_data;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    spi_bit_engine #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) u_engine (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .shift_en  (shift_en),
        .load_data (load_data),
        .miso      (miso),
        .byte_done (byte_done),
        .sclk      (sclk),
        .mosi      (mosi),
        .rx_data   (rx_data)
    );

endmodule

// File: tb/tb_spi_mem_master.sv
// Directed bench for spi_mem_master with a small SPI slave model on the pins.
module tb_spi_mem_master;

    localparam int CD     = 4;
    localparam int GC     = 8;
    localparam int T_DONE = 35*CD + GC + 1;
    localparam int T_GAP  = 1 + 17*CD;
    localparam int T_DATA = T_GAP + GC;

    logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0, rw = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       busy, done, sclk, cs_n, mosi, miso;
    logic [7:0] rdata;

    int         checks = 0, errors = 0;
    int         rise_cnt = 0, sclk_viol = 0, done_cnt = 0, hi_cnt = 0, last_hi = 0;
    logic [15:0] mosi_sh = '0;
    logic [7:0] sdata = '0;

    always #5 clk = ~clk;

    spi_mem_master #(.DATA_W(8), .CLK_DIV(CD), .GAP_CYCLES(GC)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .sclk(sclk),
        .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    // Slave model: capture mosi on SCLK rise, present sdata MSB-first during byte 1.
    always @(posedge sclk or negedge cs_n) begin
        if (sclk) begin
            rise_cnt <= rise_cnt + 1;
            mosi_sh  <= {mosi_sh[14:0], mosi};
            if (cs_n) sclk_viol <= sclk_viol + 1;
        end else begin
            rise_cnt <= 0;
            mosi_sh  <= '0;
        end
    end

    assign miso = (rise_cnt >= 8 && rise_cnt < 16) ? sdata[3'(15 - rise_cnt)] : 1'b0;

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (cs_n) hi_cnt <= hi_cnt + 1;
        else begin
            if (hi_cnt != 0) last_hi <= hi_cnt;
            hi_cnt <= 0;
        end
    end

    // Called at a negedge; start is sampled on the next edge (edge 0 of the frame).
    task automatic run_frame(input logic r, input logic [6:0] a, input logic [7:0] wd,
                             input bit inject, input int abort_at, output int n,
                             output logic b0, output logic c0, output logic b1, output logic c1,
                             output int gap_bad, output int mosi_bad, output bit tmo);
        gap_bad = 0; mosi_bad = 0; tmo = 1'b0;
        b0 = 1'bx; c0 = 1'bx; b1 = 1'bx; c1 = 1'bx;
        start = 1'b1; rw = r; addr = a; wdata = wd;
        @(posedge clk);
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            start = inject && (n == 19 || n == 59);
            if (inject) begin rw = 1'b0; addr = 7'h7F; wdata = 8'h00; end
            if (n == 0) begin b0 = busy; c0 = cs_n; end
            if (n == 1) begin b1 = busy; c1 = cs_n; end
            if (n >= T_GAP && n < T_DATA &&
                (sclk !== 1'b0 || cs_n !== 1'b0 || mosi !== (r ? wd[7] : 1'b0))) gap_bad++;
            if (!r && n >= T_DATA && n < T_DATA + 16*CD && mosi !== 1'b0) mosi_bad++;
            if (n == abort_at) begin
                reset_n = 1'b0;
                #1;
                return;
            end
            if (done) return;
            @(posedge clk);
            n++;
        end
        tmo = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        int n, gb, mb, dc; logic b0, c0, b1, c1; bit tmo;
        dc = done_cnt; sdata = 8'h00;
        run_frame(1'b1, 7'h15, 8'hA5, 1'b0, -1, n, b0, c0, b1, c1, gb, mb, tmo);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL wr_timeout: no done within bound"); end
        checks++; if (n != T_DONE) begin errors++; $display("FAIL wr_done_edge: got %0d want %0d", n, T_DONE); end
        checks++; if (b0 !== 1'b0 || c0 !== 1'b1) begin errors++; $display("FAIL wr_edge0: busy=%b cs_n=%b want 0/1", b0, c0); end
        checks++; if (b1 !== 1'b1 || c1 !== 1'b0) begin errors++; $display("FAIL wr_edge1: busy=%b cs_n=%b want 1/0", b1, c1); end
        checks++; if (mosi_sh !== 16'h95A5) begin errors++; $display("FAIL wr_frame: got %h want 95A5", mosi_sh); end
        checks++; if (rise_cnt != 16) begin errors++; $display("FAIL wr_sclk_rises: got %0d want 16", rise_cnt); end
        checks++; if (gb != 0) begin errors++; $display("FAIL wr_gap: %0d bad gap cycles want 0", gb); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL wr_rdata: got %h want 00", rdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_at_done: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        checks++; if (done_cnt != dc + 1) begin errors++; $display("FAIL wr_done_count: got %0d want %0d", done_cnt - dc, 1); end
    endtask

    task automatic test_read();
        int n, gb, mb; logic b0, c0, b1, c1; bit tmo;
        sdata = 8'h3C;
        run_frame(1'b0, 7'h2A, 8'hFF, 1'b0, -1, n, b0, c0, b1, c1, gb, mb, tmo);
        checks++; if (n != T_DONE) begin errors++; $display("FAIL rd_done_edge: got %0d want %0d", n, T_DONE); end
        checks++; if (mosi_sh !== 16'h2A00) begin errors++; $display("FAIL rd_frame: got %h want 2A00", mosi_sh); end
        checks++; if (mb != 0) begin errors++; $display("FAIL rd_mosi_low: %0d cycles with mosi=1 want 0", mb); end
        checks++; if (gb != 0) begin errors++; $display("FAIL rd_gap: %0d bad gap cycles want 0", gb); end
        checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL rd_rdata: got %h want 3C", rdata); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ignored_start();
        int n, gb, mb, dc; logic b0, c0, b1, c1; bit tmo;
        dc = done_cnt; sdata = 8'h00;
        run_frame(1'b1, 7'h15, 8'hA5, 1'b1, -1, n, b0, c0, b1, c1, gb, mb, tmo);
        checks++; if (n != T_DONE) begin errors++; $display("FAIL ign_done_edge: got %0d want %0d", n, T_DONE); end
        checks++; if (mosi_sh !== 16'h95A5) begin errors++; $display("FAIL ign_frame: got %h want 95A5", mosi_sh); end
        repeat (200) @(negedge clk);
        checks++; if (done_cnt != dc + 1) begin errors++; $display("FAIL ign_done_count: got %0d want 1", done_cnt - dc); end
        checks++; if (busy !== 1'b0 || cs_n !== 1'b1) begin errors++; $display("FAIL ign_idle: busy=%b cs_n=%b want 0/1", busy, cs_n); end
    endtask

    task automatic test_abort();
        int n, gb, mb, dc; logic b0, c0, b1, c1; bit tmo;
        int pts[2] = '{70, 100};
        foreach (pts[i]) begin
            dc = done_cnt;
            run_frame(1'b1, 7'h15, 8'hA5, 1'b0, pts[i], n, b0, c0, b1, c1, gb, mb, tmo);
            checks++; if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL abort_%0d: cs_n=%b sclk=%b busy=%b want 1/0/0", pts[i], cs_n, sclk, busy); end
            repeat (3) @(negedge clk);
            reset_n = 1'b1;
            repeat (20) @(negedge clk);
            checks++; if (done_cnt != dc) begin errors++; $display("FAIL abort_%0d_no_done: got %0d dones want 0", pts[i], done_cnt - dc); end
        end
        run_frame(1'b1, 7'h55, 8'h3C, 1'b0, -1, n, b0, c0, b1, c1, gb, mb, tmo);
        checks++; if (n != T_DONE) begin errors++; $display("FAIL abort_next_edge: got %0d want %0d", n, T_DONE); end
        checks++; if (mosi_sh !== 16'hD53C) begin errors++; $display("FAIL abort_next_frame: got %h want D53C", mosi_sh); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n1, n2, gb, mb; logic b0, c0, b1, c1; bit tmo;
        sdata = 8'hC3;
        run_frame(1'b0, 7'h11, 8'h00, 1'b0, -1, n1, b0, c0, b1, c1, gb, mb, tmo);
        checks++; if (n1 != T_DONE) begin errors++; $display("FAIL b2b_rd_edge: got %0d want %0d", n1, T_DONE); end
        checks++; if (rdata !== 8'hC3) begin errors++; $display("FAIL b2b_rd_rdata: got %h want C3", rdata); end
        checks++; if (mosi_sh !== 16'h1100) begin errors++; $display("FAIL b2b_rd_frame: got %h want 1100", mosi_sh); end
        // start is raised in the done cycle itself
        run_frame(1'b1, 7'h7F, 8'h5A, 1'b0, -1, n2, b0, c0, b1, c1, gb, mb, tmo);
        checks++; if (n2 != T_DONE) begin errors++; $display("FAIL b2b_wr_edge: got %0d want %0d", n2, T_DONE); end
        checks++; if (mosi_sh !== 16'hFF5A) begin errors++; $display("FAIL b2b_wr_frame: got %h want FF5A", mosi_sh); end
        checks++; if (rdata !== 8'hC3) begin errors++; $display("FAIL b2b_rdata_hold: got %h want C3", rdata); end
        checks++; if (last_hi < CD) begin errors++; $display("FAIL b2b_cs_gap: got %0d cycles want >= %0d", last_hi, CD); end
        checks++; if (sclk_viol != 0) begin errors++; $display("FAIL sclk_while_cs_high: got %0d want 0", sclk_viol); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_ignored_start();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
